// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave among NUM_MASTERS masters.
// The grant is held for a whole bus cycle; a watchdog reclaims the bus from a stalled owner.
module wb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic [NUM_MASTERS-1:0]            M_CYC_I,
  input  logic [NUM_MASTERS-1:0]            M_STB_I,
  input  logic [NUM_MASTERS-1:0]            M_WE_I,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADR_I,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_DAT_I,
  output logic [DATA_WIDTH-1:0]             M_DAT_O,
  output logic [NUM_MASTERS-1:0]            M_ACK_O,
  output logic [NUM_MASTERS-1:0]            M_STALL_O,
  output logic [NUM_MASTERS-1:0]            GNT,
  output logic                              S_CYC_O,
  output logic                              S_STB_O,
  output logic                              S_WE_O,
  output logic [ADDR_WIDTH-1:0]             S_ADR_O,
  output logic [DATA_WIDTH-1:0]             S_DAT_O,
  input  logic [DATA_WIDTH-1:0]             S_DAT_I,
  input  logic                              S_ACK_I,
  input  logic                              S_STALL_I,
  output logic                              TIMEOUT_O,
  output logic [2:0]                        OWNER_O
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWNED = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  localparam int              WD_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [2:0]      OWNER_RST = 3'(NUM_MASTERS - 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [2:0]             owner_q, owner_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   timeout_q, timeout_d;

  logic                   owned;
  logic                   own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic                   progress;

  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [2:0]             pick_owner;
  logic [NUM_MASTERS-1:0] pick_gnt;

  assign owned = (state_q == ST_OWNED);

  // gnt_q is one-hot of the owner while OWNED and zero otherwise, so it doubles as the mux select
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        own_cyc = M_CYC_I[i];
        own_stb = M_STB_I[i];
        own_we  = M_WE_I[i];
        own_adr = M_ADR_I[i*ADDR_WIDTH +: ADDR_WIDTH];
        own_dat = M_DAT_I[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign S_CYC_O   = owned & own_cyc;
  assign S_STB_O   = owned & own_stb;
  assign S_WE_O    = owned & own_we;
  assign S_ADR_O   = owned ? own_adr : '0;
  assign S_DAT_O   = owned ? own_dat : '0;
  assign M_DAT_O   = S_DAT_I;
  assign M_ACK_O   = owned ? (gnt_q & {NUM_MASTERS{S_ACK_I}}) : '0;
  assign M_STALL_O = owned ? (~gnt_q | {NUM_MASTERS{S_STALL_I}}) : '1;
  assign GNT       = gnt_q;
  assign TIMEOUT_O = timeout_q;
  assign OWNER_O   = owner_q;

  assign progress = S_ACK_I | (S_STB_O & ~S_STALL_I);
  assign req      = M_CYC_I & ~mask_q;

  // Scan starts just after the previous owner, which is what keeps a fast re-requester from starving others
  always_comb begin
    found      = 1'b0;
    pick_owner = owner_q;
    pick_gnt   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!found && req[j] && (j == (int'(owner_q) + k) % NUM_MASTERS)) begin
          found       = 1'b1;
          pick_owner  = 3'(j);
          pick_gnt[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
    mask_d    = mask_q & M_CYC_I;
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (found) begin
          owner_d = pick_owner;
          gnt_d   = pick_gnt;
          state_d = ST_OWNED;
        end
      end
      ST_OWNED: begin
        // A normal release wins over a watchdog expiry in the same cycle
        if (!own_cyc) begin
          gnt_d   = '0;
          wdog_d  = '0;
          state_d = ST_GUARD;
        end else if (progress) begin
          wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
          timeout_d = 1'b1;
          gnt_d     = '0;
          wdog_d    = '0;
          mask_d    = mask_q & M_CYC_I | gnt_q;
          state_d   = ST_GUARD;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      ST_GUARD: begin
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWNER_RST;
      gnt_q     <= '0;
      mask_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      mask_q    <= mask_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed self-checking bench for wb_bus_arbiter: grant latency, round robin,
// stall routing, watchdog timeout and masking, simultaneous expiry and mid-cycle reset.
module tb_wb_bus_arbiter;

  localparam int NM = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    mCyc, mStb, mWe;
  logic [NM*AW-1:0] mAdr;
  logic [NM*DW-1:0] mDat;
  logic [DW-1:0]    mDatO;
  logic [NM-1:0]    mAck, mStall, gnt;
  logic             sCyc, sStb, sWe;
  logic [AW-1:0]    sAdr;
  logic [DW-1:0]    sDatO, sDatI;
  logic             sAck, sStall;
  logic             timeoutO;
  logic [2:0]       ownerO;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .M_CYC_I(mCyc), .M_STB_I(mStb), .M_WE_I(mWe), .M_ADR_I(mAdr), .M_DAT_I(mDat),
    .M_DAT_O(mDatO), .M_ACK_O(mAck), .M_STALL_O(mStall), .GNT(gnt),
    .S_CYC_O(sCyc), .S_STB_O(sStb), .S_WE_O(sWe), .S_ADR_O(sAdr), .S_DAT_O(sDatO),
    .S_DAT_I(sDatI), .S_ACK_I(sAck), .S_STALL_I(sStall),
    .TIMEOUT_O(timeoutO), .OWNER_O(ownerO)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                               input logic [NM-1:0] we, input logic ack, input logic stall);
    mCyc   = cyc;
    mStb   = stb;
    mWe    = we;
    sAck   = ack;
    sStall = stall;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setMaster(input int idx, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    mAdr[idx*AW +: AW] = adr;
    mDat[idx*DW +: DW] = dat;
  endtask

  task automatic resetDut();
    rst   = 1'b1;
    mAdr  = '0;
    mDat  = '0;
    sDatI = 16'h5A5A;
    applyStimulus('0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    logic [NM-1:0] cycVec;
    int            idx;

    // Reset state
    resetDut();
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_owner", 32'(ownerO), 32'd3);
    checkOutput("rst_timeout", 32'(timeoutO), 32'h0);
    checkOutput("rst_scyc", 32'(sCyc), 32'h0);
    checkOutput("rst_stall", 32'(mStall), 32'hF);
    checkOutput("dat_bcast", 32'(mDatO), 32'h5A5A);

    // Single master, two pipelined writes
    rst = 1'b0;
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("gnt_latency", 32'(gnt), 32'h0);
    tick();
    checkOutput("gnt_m0", 32'(gnt), 32'h1);
    checkOutput("owner_m0", 32'(ownerO), 32'd0);
    setMaster(0, 16'h400E, 16'hBEEF);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    checkOutput("wr1_cyc", 32'(sCyc), 32'h1);
    checkOutput("wr1_stb", 32'(sStb), 32'h1);
    checkOutput("wr1_we", 32'(sWe), 32'h1);
    checkOutput("wr1_adr", 32'(sAdr), 32'h400E);
    checkOutput("wr1_dat", 32'(sDatO), 32'hBEEF);
    tick();
    setMaster(0, 16'h400F, 16'hCAFE);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0);
    checkOutput("wr2_adr", 32'(sAdr), 32'h400F);
    checkOutput("wr2_dat", 32'(sDatO), 32'hCAFE);
    checkOutput("wr_ack1", 32'(mAck), 32'h1);
    tick();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0);
    checkOutput("wr_ack2", 32'(mAck), 32'h1);
    checkOutput("wr_stb_low", 32'(sStb), 32'h0);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("rel_scyc", 32'(sCyc), 32'h0);
    tick();
    checkOutput("guard_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("idle_gnt", 32'(gnt), 32'h0);

    // Round robin with all four masters requesting
    resetDut();
    rst    = 1'b0;
    cycVec = 4'b1111;
    applyStimulus(cycVec, '0, '0, 1'b0, 1'b0);
    tick();
    for (int g = 0; g < 5; g++) begin
      idx = g % NM;
      checkOutput($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(1 << idx));
      checkOutput($sformatf("rr_owner%0d", g), 32'(ownerO), 32'(idx));
      if (g < 4) begin
        applyStimulus(cycVec, '0, '0, 1'b1, 1'b0);
        checkOutput($sformatf("rr_ack%0d", g), 32'(mAck), 32'(1 << idx));
        tick();
        tick();
        cycVec[idx] = 1'b0;
        applyStimulus(cycVec, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput($sformatf("rr_guard%0d", g), 32'(gnt), 32'h0);
        cycVec[idx] = 1'b1;
        applyStimulus(cycVec, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
      end
    end

    // Master 2 owns, master 1 waits, slave stalls for five cycles
    resetDut();
    rst = 1'b0;
    applyStimulus(4'b0100, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("st_gnt2", 32'(gnt), 32'h4);
    setMaster(1, 16'h9999, 16'h1111);
    setMaster(2, 16'h1234, 16'h2222);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b0110, 4'b0110, 4'b0010, 1'b0, 1'b1);
      checkOutput($sformatf("st_stall%0d", k), 32'(mStall), 32'hF);
      checkOutput($sformatf("st_adr%0d", k), 32'(sAdr), 32'h1234);
      checkOutput($sformatf("st_we%0d", k), 32'(sWe), 32'h0);
      tick();
    end
    applyStimulus(4'b0110, 4'b0110, 4'b0010, 1'b0, 1'b0);
    checkOutput("st_release", 32'(mStall), 32'hB);
    checkOutput("st_gnt_hold", 32'(gnt), 32'h4);
    tick();
    applyStimulus(4'b0110, 4'b0010, 4'b0010, 1'b1, 1'b0);
    checkOutput("st_ack", 32'(mAck), 32'h4);
    checkOutput("st_no_leak", 32'(sStb), 32'h0);
    tick();
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
    tick();
    checkOutput("st_guard", 32'(gnt), 32'h0);
    tick();
    checkOutput("st_idle", 32'(gnt), 32'h0);
    tick();
    checkOutput("st_gnt1", 32'(gnt), 32'h2);
    checkOutput("st_adr1", 32'(sAdr), 32'h9999);

    // Watchdog timeout, masking, other master served two cycles later
    resetDut();
    rst = 1'b0;
    applyStimulus(4'b0001, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("to_gnt0", 32'(gnt), 32'h1);
    applyStimulus(4'b0011, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("to_hold_gnt", 32'(gnt), 32'h1);
    checkOutput("to_hold_pulse", 32'(timeoutO), 32'h0);
    tick();
    checkOutput("to_pulse", 32'(timeoutO), 32'h1);
    checkOutput("to_gnt_clr", 32'(gnt), 32'h0);
    applyStimulus(4'b0011, '0, '0, 1'b1, 1'b0);
    checkOutput("to_ack_drop", 32'(mAck), 32'h0);
    tick();
    applyStimulus(4'b0011, '0, '0, 1'b0, 1'b0);
    checkOutput("to_pulse_end", 32'(timeoutO), 32'h0);
    checkOutput("to_idle_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("to_gnt1", 32'(gnt), 32'h2);
    applyStimulus(4'b0001, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("to_masked", 32'(gnt), 32'h0);
    applyStimulus(4'b0000, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("to_unmask_idle", 32'(gnt), 32'h0);
    applyStimulus(4'b0001, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("to_regrant", 32'(gnt), 32'h1);

    // Owner drops CYC on the expiry cycle: normal release
    applyStimulus(4'b0011, '0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) tick();
    checkOutput("sim_hold", 32'(gnt), 32'h1);
    applyStimulus(4'b0010, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("sim_no_pulse", 32'(timeoutO), 32'h0);
    checkOutput("sim_gnt_clr", 32'(gnt), 32'h0);
    tick();
    tick();
    checkOutput("sim_gnt1", 32'(gnt), 32'h2);

    // Reset during a granted transfer
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("mr_gnt", 32'(gnt), 32'h0);
    checkOutput("mr_scyc", 32'(sCyc), 32'h0);
    checkOutput("mr_owner", 32'(ownerO), 32'd3);
    rst = 1'b0;
    applyStimulus(4'b1111, '0, '0, 1'b0, 1'b0);
    tick();
    checkOutput("mr_gnt0", 32'(gnt), 32'h1);
    checkOutput("mr_owner0", 32'(ownerO), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
